// File: rtl/register_file_32x32_if.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_32x32_if
//  Brief    : Address/data/strobe bundle between the datapath control and the
//             32x32 register file.
//  Revision : 1.0  initial release
// ============================================================================
interface register_file_32x32_if;
  logic [4:0]  ADDR_R1;
  logic [4:0]  ADDR_R2;
  logic [4:0]  ADDR_W;
  logic [31:0] DATA_W;
  logic        READ;
  logic        WRITE;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;

  modport master (
    output ADDR_R1, ADDR_R2, ADDR_W, DATA_W, READ, WRITE,
    input  DATA_R1, DATA_R2
  );

  modport slave (
    input  ADDR_R1, ADDR_R2, ADDR_W, DATA_W, READ, WRITE,
    output DATA_R1, DATA_R2
  );
endinterface
`default_nettype wire

// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_32x32
//  Brief    : 32-entry x 32-bit register file, R0 hardwired to zero, clocked
//             dual read port, single write port, exclusive READ/WRITE strobes.
//  Revision : 1.0  initial release
// ============================================================================
module register_file_32x32 (
  input  wire logic             CLK,
  input  wire logic             RESET,
  register_file_32x32_if.slave  rf
);

  logic        w_write_en;
  logic        w_read_en;
  logic [31:1] w_dec;
  logic [31:0] r_regs [1:31];
  logic [31:0] w_file [0:31];
  logic [31:0] r_data_r1;
  logic [31:0] r_data_r2;

  // Both strobes high is treated exactly like idle.
  assign w_write_en = rf.WRITE & ~rf.READ;
  assign w_read_en  = rf.READ  & ~rf.WRITE;

  // 5-to-32 write decode; line 0 has no storage behind it.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_dec
      assign w_dec[gi] = (rf.ADDR_W == 5'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_write_en && w_dec[i]) begin
          r_regs[i] <= rf.DATA_W;
        end
      end
    end
  end

  assign w_file[0] = '0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_file
      assign w_file[gi] = r_regs[gi];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_data_r1 <= '0;
      r_data_r2 <= '0;
    end else if (w_read_en) begin
      r_data_r1 <= w_file[rf.ADDR_R1];
      r_data_r2 <= w_file[rf.ADDR_R2];
    end
  end

  assign rf.DATA_R1 = r_data_r1;
  assign rf.DATA_R2 = r_data_r2;

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_32x32
//  Brief    : Directed bench for register_file_32x32 with a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_file_32x32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   check_en;

  logic [31:0] mem  [0:31];
  logic [31:0] exp1;
  logic [31:0] exp2;

  register_file_32x32_if rf_bus ();

  register_file_32x32 dut (
    .CLK   (clk),
    .RESET (rst_n),
    .rf    (rf_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference model: an array of words, updated per the strobe rules.
  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    exp1 = '0;
    exp2 = '0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n) begin
      if (rf_bus.READ && !rf_bus.WRITE) begin
        exp1 = mem[rf_bus.ADDR_R1];
        exp2 = mem[rf_bus.ADDR_R2];
      end else if (rf_bus.WRITE && !rf_bus.READ && rf_bus.ADDR_W != 5'd0) begin
        mem[rf_bus.ADDR_W] = rf_bus.DATA_W;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      chk("model_r1", rf_bus.DATA_R1, exp1);
      chk("model_r2", rf_bus.DATA_R2, exp2);
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rf_bus.READ = 1'b0; rf_bus.WRITE = 1'b1;
    rf_bus.ADDR_W = a;  rf_bus.DATA_W = d;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rf_bus.READ = 1'b1; rf_bus.WRITE = 1'b0;
    rf_bus.ADDR_R1 = a1; rf_bus.ADDR_R2 = a2;
  endtask

  task automatic do_idle();
    @(negedge clk);
    rf_bus.READ = 1'b0; rf_bus.WRITE = 1'b0;
  endtask

  // Hand-computed expectation just after the edge that applies the last op.
  task automatic lit(input string name, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk);
    #1;
    chk({name, "_r1"}, rf_bus.DATA_R1, e1);
    chk({name, "_r2"}, rf_bus.DATA_R2, e2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    errors = 0;
    checks = 0;
    check_en = 1'b0;
    rst_n = 1'b0;
    rf_bus.READ = 1'b0; rf_bus.WRITE = 1'b0;
    rf_bus.ADDR_R1 = '0; rf_bus.ADDR_R2 = '0;
    rf_bus.ADDR_W = '0;  rf_bus.DATA_W = '0;
    model_clear();
    #12;
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("reset_r1", rf_bus.DATA_R1, 32'h0);
    chk("reset_r2", rf_bus.DATA_R2, 32'h0);

    do_read(5'd1, 5'd31);
    lit("post_reset_read", 32'h0, 32'h0);

    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h0101_0101);
    do_write(5'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), 5'(31 - i));
      v1 = 32'(i) * 32'h0101_0101;
      v2 = 32'(31 - i) * 32'h0101_0101;
      lit("pair_read", v1, v2);
    end
    do_read(5'd0, 5'd0);
    lit("r0_protect", 32'h0, 32'h0);

    do_write(5'd5, 32'h1234_5678);
    do_read(5'd5, 5'd5);
    lit("r5_read", 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    rf_bus.READ = 1'b1; rf_bus.WRITE = 1'b1;
    rf_bus.ADDR_W = 5'd5; rf_bus.DATA_W = 32'hFFFF_FFFF; rf_bus.ADDR_R1 = 5'd7;
    lit("illegal_hold", 32'h1234_5678, 32'h1234_5678);
    do_read(5'd5, 5'd5);
    lit("illegal_nowrite", 32'h1234_5678, 32'h1234_5678);

    do_write(5'd3, 32'hA5A5_A5A5);
    do_read(5'd3, 5'd0);
    lit("hold_read", 32'hA5A5_A5A5, 32'h0);
    do_write(5'd3, 32'h5A5A_5A5A);
    lit("hold_write", 32'hA5A5_A5A5, 32'h0);
    do_idle();
    lit("hold_idle", 32'hA5A5_A5A5, 32'h0);
    do_read(5'd3, 5'd3);
    lit("hold_reread", 32'h5A5A_5A5A, 32'h5A5A_5A5A);

    for (int i = 1; i <= 4; i++) do_write(5'(i), 32'hC0DE_0000 + 32'(i));
    do_read(5'd1, 5'd4);
    lit("fill_read", 32'hC0DE_0001, 32'hC0DE_0004);
    @(negedge clk);
    rf_bus.READ = 1'b0; rf_bus.WRITE = 1'b1;
    rf_bus.ADDR_W = 5'd6; rf_bus.DATA_W = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_r1", rf_bus.DATA_R1, 32'h0);
    chk("async_reset_r2", rf_bus.DATA_R2, 32'h0);
    @(negedge clk);
    rf_bus.WRITE = 1'b0;
    #2;
    rst_n = 1'b1;
    do_read(5'd1, 5'd2);
    lit("mid_reset_r12", 32'h0, 32'h0);
    do_read(5'd3, 5'd4);
    lit("mid_reset_r34", 32'h0, 32'h0);
    do_read(5'd6, 5'd31);
    lit("lost_write", 32'h0, 32'h0);
    do_write(5'd2, 32'h0BAD_CAFE);
    do_read(5'd2, 5'd6);
    lit("after_reset_write", 32'h0BAD_CAFE, 32'h0);

    do_idle();
    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file_32x32.md
# register_file_32x32

Thirty-two entry, 32-bit general-purpose register file for the processor datapath. It is built from the team's 1-bit flip-flop register primitives and the 5-to-32 line decoder. It sits between instruction decode, which supplies register addresses, and the ALU and memory stage, which consume the read operands and return write-back data. Reads and writes are clocked and mutually exclusive in a given cycle, under the control unit's READ/WRITE strobes.

## Interface
Parameters: none. Depth is fixed at 32 and width at 32.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge
- RESET  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- ADDR_R1  input  5  read port 1 register index
- ADDR_R2  input  5  read port 2 register index
- ADDR_W  input  5  write register index
- DATA_W  input  32  write data
- READ  input  1  read strobe
- WRITE  input  1  write strobe
- DATA_R1  output  32  registered read data, port 1
- DATA_R2  output  32  registered read data, port 2

## Operation
Storage:
- 32 x 32-bit registers, R0..R31.
- R0 is hardwired to zero. Writes to index 0 are discarded, and reads of index 0 always return 32'h0000_0000.

Write path:
- ADDR_W is decoded to 32 one-hot lines.
- Register i loads DATA_W only when the decode line for i, WRITE and !READ are all high.
- All other registers hold their value.

Read path:
- Two independent 32:1 muxes select by ADDR_R1 and ADDR_R2.
- Each mux result feeds a 32-bit output register that loads only when READ && !WRITE.

Strobe combinations:
- READ=1, WRITE=0: read cycle. Both output registers capture the selected contents. The register array is unchanged.
- READ=0, WRITE=1: write cycle. One register (unless index 0) is updated. DATA_R1 and DATA_R2 hold.
- READ=0, WRITE=0: idle. All state holds.
- READ=1, WRITE=1: illegal. It is treated as idle: no write, outputs hold. This is not an error condition, and no flag is raised.

Other rules:
- ADDR_R1 == ADDR_R2 is legal; both ports return the same value.
- Reset state: all 32 registers = 0, DATA_R1 = 0, DATA_R2 = 0.

## Timing
- Read latency is 1 cycle. ADDR_R1/ADDR_R2 are sampled at the rising edge with READ=1, and DATA_R1/DATA_R2 are valid after that edge. They stay stable until the next read edge or reset.
- Write latency: a write at edge N is visible to a read issued at edge N+1 or later. There is no same-edge bypass, because read and write cannot coincide.
- Inputs must be stable for setup/hold around the rising edge. Strobes are level-sensitive at the edge, not edge-detected.
- RESET low forces all registers and outputs to zero immediately, with no clock required.
- While RESET is low, clock edges have no effect.
- A write coincident with RESET assertion is lost.
- Release of RESET: the first edge at which RESET is high performs normal operation.
- Reset mid-sequence: any prior write contents are cleared. A subsequent read of any index returns 0 until it is rewritten.
- Outputs never glitch between read edges. They are driven only from flip-flops.

## Test plan
- Reset: drive RESET=0 mid-cycle with no clock edge. DATA_R1 and DATA_R2 must go to 0 immediately. After release, a read of R1/R31 must return 0/0.
- Write/read all registers: write i * 32'h0101_0101 to Ri for i = 1..31, then read pairs (i, 31-i). Each port must return its own written value one edge later. Reads of R0 must return 0.
- R0 protection: write 32'hDEAD_BEEF to index 0, then read (0, 0). Both ports must return 0.
- Illegal strobes: write R5 = 32'h1234_5678, then read R5. Next, apply READ=WRITE=1 with ADDR_W=5, DATA_W=32'hFFFF_FFFF and ADDR_R1=7. Both outputs must hold 32'h1234_5678, and a subsequent read of R5 must still return 32'h1234_5678.
- Hold behaviour: read R3 = 32'hA5A5_A5A5 on port 1, then write R3 = 32'h5A5A_5A5A. DATA_R1 must stay 32'hA5A5_A5A5 until the next read edge, after which it must show 32'h5A5A_5A5A.
- Reset mid-operation: fill R1..R4 with nonzero values and pulse RESET low between clock edges. Reads of R1..R4 must then return 0, and a write issued on the edge during reset must not take effect.
